// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_ctrl
//  Function : 4-digit 7-segment scan controller with frame-aligned,
//             tear-free BCD value update. Optional leading-zero blanking
//             is enabled by defining SEVEN_SEG_LEADING_ZERO_BLANK_EN.
//  Revision : 1.0
// ============================================================================
module seven_seg_scan_ctrl #(
    parameter int DIV_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        value_we,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done,
    output logic        pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_CYCLES - 1);
    localparam logic [6:0]       SEG_OFF = 7'h7F;
    localparam logic [3:0]       AN_OFF  = 4'b1111;

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [1:0]       idx_q,  idx_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pval_q, pval_d;
    logic             pend_q, pend_d;
    logic [3:0]       an_q,   an_d;
    logic [6:0]       seg_q,  seg_d;
    logic             fd_q;

    logic             tick;
    logic             boundary;
    logic [3:0]       nibble;
    logic             blank;

    assign tick     = enable && (cnt_q == CNT_MAX);
    assign boundary = tick && (idx_q == 2'd3);
    assign nibble   = disp_q[{idx_q, 2'b00} +: 4];

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (enable) begin
            if (tick) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A write coinciding with the frame boundary bypasses the pending slot so
    // the newest value is never held back a whole frame.
    always_comb begin
        disp_d = disp_q;
        pval_d = pval_q;
        pend_d = pend_q;
        if (boundary && value_we) begin
            disp_d = value_in;
            pend_d = 1'b0;
        end else if (value_we) begin
            pval_d = value_in;
            pend_d = 1'b1;
        end else if (boundary && pend_q) begin
            disp_d = pval_q;
            pend_d = 1'b0;
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [3:1] zero;
    assign zero[1] = (disp_q[7:4]   == 4'd0);
    assign zero[2] = (disp_q[11:8]  == 4'd0);
    assign zero[3] = (disp_q[15:12] == 4'd0);

    // Digit 0 is never blanked so an all-zero value still shows a single 0.
    always_comb begin
        blank = 1'b0;
        case (idx_q)
            2'd3:    blank = zero[3];
            2'd2:    blank = zero[3] && zero[2];
            2'd1:    blank = zero[3] && zero[2] && zero[1];
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (enable) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = blank ? SEG_OFF : decode(nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            disp_q <= 16'h0000;
            pval_q <= 16'h0000;
            pend_q <= 1'b0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_OFF;
            fd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            pval_q <= pval_d;
            pend_q <= pend_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            fd_q   <= boundary;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;
    assign pending    = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scan_ctrl
//  Function : Directed scoreboard bench for seven_seg_scan_ctrl (DIV_CYCLES=4).
//  Revision : 1.0
// ============================================================================
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic        value_we;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;
    logic        pending;

    seven_seg_scan_ctrl #(
        .DIV_CYCLES (4),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .value_we   (value_we),
        .enable     (enable),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t        sb[$];
    int          total  = 0;
    int          passed = 0;
    int          sample = 0;

    int          m_cnt  = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_pval = 16'h0000;
    logic        m_pend = 1'b0;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic blank(input int k, input logic [15:0] v);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (k == 0) return 1'b0;
        for (int j = k; j < 4; j++)
            if (v[j*4 +: 4] != 4'd0) return 1'b0;
        return 1'b1;
`else
        return (k < 0) && (v != v);
`endif
    endfunction

    // One clock: drive inputs, push the expected post-edge outputs, then pop and compare.
    task automatic cyc(input logic r, input logic en, input logic we, input logic [15:0] v);
        exp_t e;
        exp_t got;
        logic bnd;
        int   ix;
        reset    = r;
        enable   = en;
        value_we = we;
        value_in = v;
        bnd      = 1'b0;
        e.an     = 4'b1111;
        e.seg    = 7'h7F;
        e.fd     = 1'b0;
        if (r) begin
            m_cnt  = 0;
            m_disp = 16'h0000;
            m_pval = 16'h0000;
            m_pend = 1'b0;
        end else begin
            if (en) begin
                ix    = (m_cnt / 4) % 4;
                e.an  = ~(4'b0001 << ix);
                e.seg = blank(ix, m_disp) ? 7'h7F : dec(m_disp[ix*4 +: 4]);
                bnd   = (m_cnt % 16) == 15;
                e.fd  = bnd;
                m_cnt++;
            end
            if (bnd && we) begin
                m_disp = v;
                m_pend = 1'b0;
            end else if (we) begin
                m_pval = v;
                m_pend = 1'b1;
            end else if (bnd && m_pend) begin
                m_disp = m_pval;
                m_pend = 1'b0;
            end
        end
        e.pend = m_pend;
        sb.push_back(e);
        @(posedge clk);
        #1;
        sample++;
        got = sb.pop_front();
        total++;
        assert ({an, seg, frame_done, pending} === got) passed++;
        else $error("FAIL out@%0d: observed an=%b seg=%h fd=%b pend=%b expected an=%b seg=%h fd=%b pend=%b",
                    sample, an, seg, frame_done, pending, got.an, got.seg, got.fd, got.pend);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        value_we = 1'b0;
        value_in = 16'h0000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

        sample = 0;
        // Frame 1 shows zeros while 1890 waits; frame 2 shows 1890.
        cyc(1'b0, 1'b1, 1'b1, 16'h1890);
        idle(36);
        // Tear-free write during digit 1 of frame 3.
        cyc(1'b0, 1'b1, 1'b1, 16'h1234);
        idle(13);
        // 5555 pending, then 7777 written on the boundary cycle.
        cyc(1'b0, 1'b1, 1'b1, 16'h5555);
        idle(11);
        cyc(1'b0, 1'b1, 1'b1, 16'h7777);
        idle(5);
        // Invalid BCD nibble in digit 1.
        cyc(1'b0, 1'b1, 1'b1, 16'h00A0);
        idle(28);
        // Blanked for 10 cycles with a write accepted meanwhile.
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b0, (i == 4), 16'h0007);
        idle(30);
        // Reset mid-frame discards pending data.
        idle(6);
        cyc(1'b0, 1'b1, 1'b1, 16'h4321);
        idle(1);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        idle(20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
